axi_full_mst: RTL and testbench

- Single-outstanding AXI4-full burst initiator. Drives the same AXI4 slave interface that the on-chip SRAM slave answers.
- Converts a simple request/stream interface into INCR bursts of 64-bit beats.
- Used by the memory-side agents (program loader, cache refill/writeback) and as the bus-driving counterpart in chip-level benches.
- Handles exactly one transaction (read or write) at a time. Reports completion with a one-cycle done pulse and an error flag.

---
 rtl/axi_pkg.sv | 31 +++
 rtl/axi_full_mst_if.sv | 64 ++++++
 rtl/axi_full_mst.sv | 162 ++++++++++++++++
 tb/tb_axi_full_mst.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 constants, master FSM state type and the 4KB burst-boundary helper.
package axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_B    = 3'd3,
    ST_AR   = 3'd4,
    ST_R    = 3'd5,
    ST_REJ  = 3'd6
  } state_e;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'b011;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int unsigned BOUNDARY_4KB = 4096;
  localparam int unsigned IDW          = 4;

  // True when an 8-byte-beat burst of len+1 beats starting at page offset off runs past the 4KB page.
  function automatic logic crosses_4k(input logic [11:0] off, input logic [7:0] len);
    logic [13:0] end_b;
    end_b = {2'b00, off} + {3'b000, len, 3'b000} + 14'd8;
    return end_b > 14'(BOUNDARY_4KB);
  endfunction

endpackage

// File: rtl/axi_full_mst_if.sv
// AXI4-full bus between a burst master and a slave (address, data and response channels).
interface axi_full_mst_if #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 64,
  parameter int unsigned IDW = 4
);
  logic [IDW-1:0]  M_AXI_AWID;
  logic [AW-1:0]   M_AXI_AWADDR;
  logic [7:0]      M_AXI_AWLEN;
  logic [2:0]      M_AXI_AWSIZE;
  logic [1:0]      M_AXI_AWBURST;
  logic            M_AXI_AWVALID;
  logic            M_AXI_AWREADY;

  logic [DW-1:0]   M_AXI_WDATA;
  logic [DW/8-1:0] M_AXI_WSTRB;
  logic            M_AXI_WLAST;
  logic            M_AXI_WVALID;
  logic            M_AXI_WREADY;

  logic [1:0]      M_AXI_BRESP;
  logic            M_AXI_BVALID;
  logic            M_AXI_BREADY;

  logic [IDW-1:0]  M_AXI_ARID;
  logic [AW-1:0]   M_AXI_ARADDR;
  logic [7:0]      M_AXI_ARLEN;
  logic [2:0]      M_AXI_ARSIZE;
  logic [1:0]      M_AXI_ARBURST;
  logic            M_AXI_ARVALID;
  logic            M_AXI_ARREADY;

  logic [DW-1:0]   M_AXI_RDATA;
  logic [1:0]      M_AXI_RRESP;
  logic            M_AXI_RLAST;
  logic            M_AXI_RVALID;
  logic            M_AXI_RREADY;

  modport master (
    output M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    input  M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    input  M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID,
    output M_AXI_BREADY,
    output M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
    input  M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWID, M_AXI_AWADDR, M_AXI_AWLEN, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWVALID,
    output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WLAST, M_AXI_WVALID,
    output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID,
    input  M_AXI_BREADY,
    input  M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
    output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
    input  M_AXI_RREADY
  );
endinterface

// File: rtl/axi_full_mst.sv
// Single-outstanding AXI4 INCR burst master: turns a request plus beat stream into one
// read or write burst of 64-bit beats and reports completion with a done/err pulse.
module axi_full_mst
  import axi_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 64,
  parameter int unsigned ID = 0
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_wen,
  input  logic [AW-1:0] req_addr,
  input  logic [7:0]    req_len,
  input  logic [63:0]   wr_data,
  input  logic [7:0]    wr_strb,
  input  logic          wr_valid,
  output logic          wr_ready,
  output logic [63:0]   rd_data,
  output logic          rd_last,
  output logic          rd_valid,
  input  logic          rd_ready,
  output logic          done,
  output logic          err,
  axi_full_mst_if.master m_axi
);

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          acc_q, acc_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic in_aw, in_w, in_b, in_ar, in_r;
  logic last_beat, w_hs, r_hs;

  assign in_aw     = (state_q == ST_AW);
  assign in_w      = (state_q == ST_W);
  assign in_b      = (state_q == ST_B);
  assign in_ar     = (state_q == ST_AR);
  assign in_r      = (state_q == ST_R);
  assign last_beat = (cnt_q == len_q);
  assign w_hs      = in_w && wr_valid && m_axi.M_AXI_WREADY;
  assign r_hs      = in_r && m_axi.M_AXI_RVALID && rd_ready;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          len_d  = req_len;
          cnt_d  = '0;
          acc_d  = 1'b0;
          if ((req_addr[2:0] != 3'b000) || crosses_4k(req_addr[11:0], req_len))
            state_d = ST_REJ;
          else
            state_d = req_wen ? ST_AW : ST_AR;
        end
      end
      ST_AW: if (m_axi.M_AXI_AWREADY) state_d = ST_W;
      ST_AR: if (m_axi.M_AXI_ARREADY) state_d = ST_R;
      ST_W: begin
        if (w_hs) begin
          cnt_d = cnt_q + 8'd1;
          if (last_beat) state_d = ST_B;
        end
      end
      ST_B: begin
        if (m_axi.M_AXI_BVALID) begin
          done_d  = 1'b1;
          err_d   = m_axi.M_AXI_BRESP[1];
          state_d = ST_IDLE;
        end
      end
      ST_R: begin
        if (r_hs) begin
          // RLAST must coincide exactly with the final counted beat, otherwise flag the burst.
          acc_d = acc_q | m_axi.M_AXI_RRESP[1] | (m_axi.M_AXI_RLAST ^ last_beat);
          cnt_d = cnt_q + 8'd1;
          if (m_axi.M_AXI_RLAST) begin
            done_d  = 1'b1;
            err_d   = acc_d;
            state_d = ST_IDLE;
          end
        end
      end
      ST_REJ: begin
        done_d  = 1'b1;
        err_d   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Every output is qualified by state so that reset forces the whole port to zero.
  assign req_ready = RSTn && (state_q == ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;

  assign m_axi.M_AXI_AWID    = in_aw ? IDW'(ID) : '0;
  assign m_axi.M_AXI_AWADDR  = in_aw ? addr_q : '0;
  assign m_axi.M_AXI_AWLEN   = in_aw ? len_q : '0;
  assign m_axi.M_AXI_AWSIZE  = in_aw ? SIZE_8B : '0;
  assign m_axi.M_AXI_AWBURST = in_aw ? BURST_INCR : '0;
  assign m_axi.M_AXI_AWVALID = in_aw;

  assign m_axi.M_AXI_WDATA   = in_w ? wr_data : '0;
  assign m_axi.M_AXI_WSTRB   = in_w ? wr_strb : '0;
  assign m_axi.M_AXI_WLAST   = in_w && last_beat;
  assign m_axi.M_AXI_WVALID  = in_w && wr_valid;
  assign wr_ready            = in_w && m_axi.M_AXI_WREADY;

  assign m_axi.M_AXI_BREADY  = in_b;

  assign m_axi.M_AXI_ARID    = in_ar ? IDW'(ID) : '0;
  assign m_axi.M_AXI_ARADDR  = in_ar ? addr_q : '0;
  assign m_axi.M_AXI_ARLEN   = in_ar ? len_q : '0;
  assign m_axi.M_AXI_ARSIZE  = in_ar ? SIZE_8B : '0;
  assign m_axi.M_AXI_ARBURST = in_ar ? BURST_INCR : '0;
  assign m_axi.M_AXI_ARVALID = in_ar;

  assign m_axi.M_AXI_RREADY  = in_r && rd_ready;
  assign rd_valid            = in_r && m_axi.M_AXI_RVALID;
  assign rd_data             = in_r ? m_axi.M_AXI_RDATA : '0;
  assign rd_last             = in_r && m_axi.M_AXI_RLAST;

  logic unused_resp_lsb;
  assign unused_resp_lsb = ^{m_axi.M_AXI_BRESP[0], m_axi.M_AXI_RRESP[0]};

endmodule

// File: tb/tb_axi_full_mst.sv
// Directed bench for axi_full_mst with a small configurable SRAM-like AXI slave.
module tb_axi_full_mst;
  import axi_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        req_valid, req_wen;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic        wr_valid, wr_ready;
  logic [63:0] rd_data;
  logic        rd_last, rd_valid;
  logic        rd_ready;
  logic        done, err;

  always #5 CLK = ~CLK;

  axi_full_mst_if #(.AW(32), .DW(64), .IDW(IDW)) bus ();

  axi_full_mst #(.AW(32), .DW(64), .ID(0)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .err(err),
    .m_axi(bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int          aw_delay = 0, w_stall = 0, err_beat = -1;
  logic [1:0]  bresp_cfg = RESP_OKAY;
  logic [63:0] mem [0:511];
  int          sst, dly, stall, rlen, rcnt;
  logic [8:0]  sidx;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      sst <= 0; dly <= 0; stall <= 0; rlen <= 0; rcnt <= 0; sidx <= '0;
      bus.M_AXI_AWREADY <= 1'b0; bus.M_AXI_WREADY <= 1'b0;
      bus.M_AXI_BVALID <= 1'b0;  bus.M_AXI_BRESP <= 2'b00;
      bus.M_AXI_ARREADY <= 1'b0; bus.M_AXI_RVALID <= 1'b0;
      bus.M_AXI_RDATA <= '0; bus.M_AXI_RRESP <= 2'b00; bus.M_AXI_RLAST <= 1'b0;
    end else begin
      case (sst)
        0: begin
          if (bus.M_AXI_AWVALID) begin
            if (dly >= aw_delay) begin bus.M_AXI_AWREADY <= 1'b1; sst <= 1; end
            else dly <= dly + 1;
          end else if (bus.M_AXI_ARVALID) begin
            bus.M_AXI_ARREADY <= 1'b1; sst <= 4;
          end
        end
        1: begin
          bus.M_AXI_AWREADY <= 1'b0; sidx <= bus.M_AXI_AWADDR[11:3]; stall <= 0; sst <= 2;
        end
        2: begin
          if (bus.M_AXI_WREADY && bus.M_AXI_WVALID) begin
            for (int b = 0; b < 8; b++)
              if (bus.M_AXI_WSTRB[b]) mem[sidx][b*8 +: 8] <= bus.M_AXI_WDATA[b*8 +: 8];
            sidx <= sidx + 9'd1; bus.M_AXI_WREADY <= 1'b0; stall <= 0;
            if (bus.M_AXI_WLAST) begin
              bus.M_AXI_BVALID <= 1'b1; bus.M_AXI_BRESP <= bresp_cfg; sst <= 3;
            end
          end else if (!bus.M_AXI_WREADY) begin
            if (stall >= w_stall) bus.M_AXI_WREADY <= 1'b1;
            else stall <= stall + 1;
          end
        end
        3: if (bus.M_AXI_BREADY) begin bus.M_AXI_BVALID <= 1'b0; dly <= 0; sst <= 0; end
        4: begin
          bus.M_AXI_ARREADY <= 1'b0;
          rlen <= int'(bus.M_AXI_ARLEN); rcnt <= 0; sidx <= bus.M_AXI_ARADDR[11:3];
          bus.M_AXI_RVALID <= 1'b1; bus.M_AXI_RDATA <= mem[bus.M_AXI_ARADDR[11:3]];
          bus.M_AXI_RLAST <= (bus.M_AXI_ARLEN == 8'd0);
          bus.M_AXI_RRESP <= (err_beat == 0) ? RESP_SLVERR : RESP_OKAY;
          sst <= 5;
        end
        5: if (bus.M_AXI_RREADY) begin
          if (bus.M_AXI_RLAST) begin
            bus.M_AXI_RVALID <= 1'b0; bus.M_AXI_RLAST <= 1'b0; dly <= 0; sst <= 0;
          end else begin
            bus.M_AXI_RDATA <= mem[sidx + 9'd1]; sidx <= sidx + 9'd1; rcnt <= rcnt + 1;
            bus.M_AXI_RLAST <= (rcnt + 1 == rlen);
            bus.M_AXI_RRESP <= (rcnt + 1 == err_beat) ? RESP_SLVERR : RESP_OKAY;
          end
        end
        default: sst <= 0;
      endcase
    end
  end

  // ---------------- producer / consumer ----------------
  logic [63:0] wvec [0:15];
  logic        wr_en = 1'b0, rd_toggle = 1'b0;
  int          wlen_tb = 0, wbeat;

  assign wr_valid = wr_en && (wbeat <= wlen_tb);
  assign wr_data  = wvec[wbeat[3:0]];
  assign wr_strb  = 8'hFF;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) wbeat <= 0;
    else if (req_valid && req_ready) wbeat <= 0;
    else if (wr_valid && wr_ready) wbeat <= wbeat + 1;
  end

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) rd_ready <= 1'b0;
    else rd_ready <= rd_toggle ? ~rd_ready : 1'b1;
  end

  // ---------------- monitor ----------------
  int          cyc = 0, acc_cyc, done_cyc, b_cyc, done_cnt = 0;
  int          ax_cnt, early_w, unstable, wlast_at, wlast_cnt, rlast_at, rr_bad;
  logic        last_err, aw_seen;
  logic [7:0]  awlen_cap;
  logic [63:0] rq [$];
  logic        prev_wv = 1'b0, prev_wr = 1'b0, prev_rst = 1'b0;
  logic [63:0] prev_wd = '0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready) begin
      acc_cyc <= cyc; aw_seen <= 1'b0; ax_cnt <= 0; early_w <= 0; unstable <= 0;
      wlast_at <= -1; wlast_cnt <= 0; rlast_at <= -1; rr_bad <= 0; rq.delete();
    end else begin
      if (bus.M_AXI_AWVALID || bus.M_AXI_ARVALID) ax_cnt <= ax_cnt + 1;
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin aw_seen <= 1'b1; awlen_cap <= bus.M_AXI_AWLEN; end
      if (bus.M_AXI_WVALID && !aw_seen) early_w <= early_w + 1;
      if (prev_wv && !prev_wr && bus.M_AXI_WVALID && (bus.M_AXI_WDATA != prev_wd)) unstable <= unstable + 1;
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY && bus.M_AXI_WLAST) begin
        wlast_at <= wbeat; wlast_cnt <= wlast_cnt + 1;
      end
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) b_cyc <= cyc;
      if (rd_valid && rd_ready) begin
        if (rd_last) rlast_at <= rq.size();
        rq.push_back(rd_data);
      end
      if (rd_valid && (bus.M_AXI_RREADY != rd_ready)) rr_bad <= rr_bad + 1;
    end
    if (done) begin done_cnt <= done_cnt + 1; done_cyc <= cyc; last_err <= err; end
    if (RSTn && prev_rst && prev_wv && !prev_wr)
      assert (bus.M_AXI_WVALID) else $error("FAIL wvalid_hold: WVALID dropped while WREADY low");
    prev_wv <= bus.M_AXI_WVALID; prev_wr <= bus.M_AXI_WREADY;
    prev_wd <= bus.M_AXI_WDATA;  prev_rst <= RSTn;
  end

  // ---------------- stimulus ----------------
  int d0;

  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [7:0] len);
    @(negedge CLK);
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge CLK);
    d0 = done_cnt;
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_len = len;
    wlen_tb = int'(len); wr_en = wen;
    @(negedge CLK);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 500 && done_cnt == d0; i++) @(negedge CLK);
    chk({tag, "_done"}, 64'(done_cnt - d0), 64'd1);
    wr_en = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RSTn = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_len = '0;
    repeat (3) @(negedge CLK);
    chk("rst_outs", 64'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID, bus.M_AXI_BREADY,
                         bus.M_AXI_RREADY, wr_ready, rd_valid, rd_last, done, err, req_ready}), 64'd0);
    RSTn = 1'b1;
    @(negedge CLK);
    chk("rst_req_ready", 64'(req_ready), 64'd1);

    // 4-beat write, slave always ready
    wvec[0] = 64'h11; wvec[1] = 64'h22; wvec[2] = 64'h33; wvec[3] = 64'h44;
    do_req(1'b1, 32'h8000_0000, 8'd3);
    wait_done("wr4");
    chk("wr4_awlen", 64'(awlen_cap), 64'd3);
    chk("wr4_wlast_at", 64'(wlast_at), 64'd3);
    chk("wr4_wlast_cnt", 64'(wlast_cnt), 64'd1);
    chk("wr4_err", 64'(last_err), 64'd0);
    chk("wr4_done_lat", 64'(done_cyc - b_cyc), 64'd1);
    for (int i = 0; i < 4; i++) chk("wr4_mem", mem[i], 64'h11 * 64'(i + 1));

    // 4-beat read back with rd_ready toggling
    rd_toggle = 1'b1;
    do_req(1'b0, 32'h8000_0000, 8'd3);
    wait_done("rd4");
    rd_toggle = 1'b0;
    chk("rd4_cnt", 64'(rq.size()), 64'd4);
    for (int i = 0; i < 4; i++) chk("rd4_data", (i < rq.size()) ? rq[i] : 64'hX, 64'h11 * 64'(i + 1));
    chk("rd4_rlast_at", 64'(rlast_at), 64'd3);
    chk("rd4_rready", 64'(rr_bad), 64'd0);
    chk("rd4_err", 64'(last_err), 64'd0);

    // stalled write: AWREADY after 5 cycles, WREADY 3 cycles late per beat
    aw_delay = 5; w_stall = 3;
    wvec[0] = 64'hA1A1_0000_0000_00A1; wvec[1] = 64'hB2B2_0000_0000_00B2; wvec[2] = 64'hC3C3_0000_0000_00C3;
    do_req(1'b1, 32'h8000_0100, 8'd2);
    wait_done("wrst");
    aw_delay = 0; w_stall = 0;
    chk("wrst_early_w", 64'(early_w), 64'd0);
    chk("wrst_unstable", 64'(unstable), 64'd0);
    chk("wrst_err", 64'(last_err), 64'd0);
    chk("wrst_mem0", mem[32], 64'hA1A1_0000_0000_00A1);
    chk("wrst_mem2", mem[34], 64'hC3C3_0000_0000_00C3);

    // 4KB crossing and misaligned requests are rejected without bus activity
    do_req(1'b1, 32'h8000_0FF8, 8'd1);
    wait_done("rej4k");
    chk("rej4k_ax", 64'(ax_cnt), 64'd0);
    chk("rej4k_err", 64'(last_err), 64'd1);
    chk("rej4k_lat", 64'(done_cyc - acc_cyc), 64'd2);
    do_req(1'b0, 32'h8000_0004, 8'd0);
    wait_done("rejal");
    chk("rejal_ax", 64'(ax_cnt), 64'd0);
    chk("rejal_err", 64'(last_err), 64'd1);
    chk("rejal_lat", 64'(done_cyc - acc_cyc), 64'd2);

    // read with SLVERR on the first beat
    err_beat = 0;
    do_req(1'b0, 32'h8000_0000, 8'd1);
    wait_done("rdse");
    err_beat = -1;
    chk("rdse_cnt", 64'(rq.size()), 64'd2);
    chk("rdse_d1", (rq.size() > 1) ? rq[1] : 64'hX, 64'h22);
    chk("rdse_err", 64'(last_err), 64'd1);

    // single-beat write answered with DECERR
    bresp_cfg = RESP_DECERR; wvec[0] = 64'h55;
    do_req(1'b1, 32'h8000_0200, 8'd0);
    wait_done("wrde");
    bresp_cfg = RESP_OKAY;
    chk("wrde_wlast_at", 64'(wlast_at), 64'd0);
    chk("wrde_err", 64'(last_err), 64'd1);
    chk("wrde_mem", mem[64], 64'h55);

    // reset in the middle of an 8-beat write
    w_stall = 1;
    for (int i = 0; i < 8; i++) wvec[i] = 64'hF0 + 64'(i);
    do_req(1'b1, 32'h8000_0300, 8'd7);
    for (int i = 0; i < 200 && wbeat < 3; i++) @(negedge CLK);
    chk("mid_reached", 64'(wbeat >= 3), 64'd1);
    d0 = done_cnt;
    RSTn = 1'b0;
    #1;
    chk("mid_rst_outs", 64'({bus.M_AXI_AWVALID, bus.M_AXI_WVALID, bus.M_AXI_ARVALID, bus.M_AXI_BREADY,
                             bus.M_AXI_RREADY, wr_ready, rd_valid, rd_last, done, err, req_ready}), 64'd0);
    chk("mid_rst_wdata", bus.M_AXI_WDATA, 64'd0);
    wr_en = 1'b0; w_stall = 0;
    @(negedge CLK); RSTn = 1'b1;
    @(negedge CLK);
    chk("mid_req_ready", 64'(req_ready), 64'd1);
    repeat (3) @(negedge CLK);
    chk("mid_no_done", 64'(done_cnt - d0), 64'd0);

    // normal operation resumes
    wvec[0] = 64'h77;
    do_req(1'b1, 32'h8000_0400, 8'd0);
    wait_done("post");
    chk("post_err", 64'(last_err), 64'd0);
    chk("post_mem", mem[128], 64'h77);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
